// File: rtl/pulp_sync_pkg.sv
// pulp_sync_pkg: edge-mode encoding and event-match helper shared by the sync/debounce block.
package pulp_sync_pkg;
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_e;
  function automatic logic edge_hit(edge_mode_e m, logic r, logic f);
    return (r && (m == EDGE_RISE || m == EDGE_BOTH)) || (f && (m == EDGE_FALL || m == EDGE_BOTH));
  endfunction
endpackage

// File: rtl/pulp_sync.sv
// pulp_sync: STAGES-deep flop chain bringing an asynchronous bit into clk_i.
module pulp_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic serial_i,
  output logic serial_o
);
  logic [STAGES-1:0] reg_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) reg_q <= {STAGES{RST_VAL}};
    else         reg_q <= {reg_q[STAGES-2:0], serial_i};
  end
  assign serial_o = reg_q[STAGES-1];
endmodule

// File: rtl/pulp_sync_debounce_ch.sv
// pulp_sync_debounce_ch: one channel -- synchroniser, glitch filter, edge pulses, sticky event flag.
module pulp_sync_debounce_ch import pulp_sync_pkg::*; #(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned FILT_W  = 8,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              serial_i,
  input  logic [FILT_W-1:0] filt_thr_i,
  input  edge_mode_e        mode_i,
  input  logic              evt_clr_i,
  output logic              serial_o,
  output logic              r_edge_o,
  output logic              f_edge_o,
  output logic              evt_o,
  output logic              evt_d_o
);
  logic s, diff, fire;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, r_q, r_d, f_q, f_d, evt_q, evt_d;
  pulp_sync #(.STAGES(STAGES), .RST_VAL(RST_VAL)) i_sync (
    .clk_i(clk_i), .rstn_i(rstn_i), .serial_i(serial_i), .serial_o(s)
  );
  // cnt >= T also covers a threshold lowered below a count already in flight
  always_comb begin
    diff  = s != lvl_q;
    fire  = en_i && diff && cnt_q >= filt_thr_i;
    cnt_d = (!en_i || !diff || fire) ? '0 : cnt_q + FILT_W'(1);
    lvl_d = fire ? s : lvl_q;
    r_d   = fire && s;
    f_d   = fire && !s;
    evt_d = edge_hit(mode_i, r_q, f_q) || (evt_q && !evt_clr_i);
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      lvl_q <= RST_VAL;
      r_q   <= 1'b0;
      f_q   <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      r_q   <= r_d;
      f_q   <= f_d;
      evt_q <= evt_d;
    end
  end
  assign serial_o = lvl_q;
  assign r_edge_o = r_q;
  assign f_edge_o = f_q;
  assign evt_o    = evt_q;
  assign evt_d_o  = evt_d;
endmodule

// File: rtl/pulp_sync_debounce.sv
// pulp_sync_debounce: N_CH independent debounced sync channels with sticky edge events and a shared irq.
module pulp_sync_debounce import pulp_sync_pkg::*; #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned FILT_W  = 8,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [N_CH-1:0]   en_i,
  input  logic [N_CH-1:0]   serial_i,
  input  logic [FILT_W-1:0] filt_thr_i,
  input  logic [2*N_CH-1:0] mode_i,
  input  logic [N_CH-1:0]   evt_clr_i,
  output logic [N_CH-1:0]   serial_o,
  output logic [N_CH-1:0]   r_edge_o,
  output logic [N_CH-1:0]   f_edge_o,
  output logic [N_CH-1:0]   evt_o,
  output logic              irq_o
);
  logic [N_CH-1:0] evt_d;
  logic irq_q;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pulp_sync_debounce_ch #(.STAGES(STAGES), .FILT_W(FILT_W), .RST_VAL(RST_VAL)) i_ch (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .en_i      (en_i[g]),
      .serial_i  (serial_i[g]),
      .filt_thr_i(filt_thr_i),
      .mode_i    (edge_mode_e'(mode_i[2*g+:2])),
      .evt_clr_i (evt_clr_i[g]),
      .serial_o  (serial_o[g]),
      .r_edge_o  (r_edge_o[g]),
      .f_edge_o  (f_edge_o[g]),
      .evt_o     (evt_o[g]),
      .evt_d_o   (evt_d[g])
    );
  end
  // irq follows the next-state flags so it lands in the same cycle as evt_o
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) irq_q <= 1'b0;
    else         irq_q <= |evt_d;
  end
  assign irq_o = irq_q;
endmodule

// File: tb/tb_pulp_sync_debounce.sv
// tb_pulp_sync_debounce: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_pulp_sync_debounce;
  import pulp_sync_pkg::*;
  localparam int N = 4, ST = 2, FW = 8;
  logic clk = 1'b0, rstn = 1'b0, irq;
  logic [N-1:0] en, sin, clr, sout, redge, fedge, evt;
  logic [FW-1:0] thr;
  logic [2*N-1:0] mode;
  int checks = 0, errors = 0, pulses, r_at, f_at;
  bit cmp_on = 1'b0;
  always #5 clk = ~clk;
  pulp_sync_debounce #(.N_CH(N), .STAGES(ST), .FILT_W(FW), .RST_VAL(1'b0)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .serial_i(sin), .filt_thr_i(thr), .mode_i(mode),
    .evt_clr_i(clr), .serial_o(sout), .r_edge_o(redge), .f_edge_o(fedge), .evt_o(evt), .irq_o(irq)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  // Model: the filtered level adopts the synced input once it has disagreed for more than T enabled cycles in a row
  logic [N-1:0] m_hist [ST];
  logic [N-1:0] m_lvl, m_r, m_f, m_evt, m_s, r_old, f_old;
  logic [1:0] md;
  logic m_irq;
  int m_run [N];
  initial begin
    for (int k = 0; k < ST; k++) m_hist[k] = '0;
    m_lvl = '0; m_r = '0; m_f = '0; m_evt = '0; m_irq = 1'b0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int k = 0; k < ST; k++) m_hist[k] = '0;
        m_lvl = '0; m_r = '0; m_f = '0; m_evt = '0; m_irq = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
      end else begin
        m_s = m_hist[ST-1];
        r_old = m_r;
        f_old = m_f;
        for (int k = ST - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = sin;
        for (int i = 0; i < N; i++) begin
          m_r[i] = 1'b0;
          m_f[i] = 1'b0;
          if (!en[i] || m_s[i] == m_lvl[i]) m_run[i] = 0;
          else if (m_run[i] >= int'(thr)) begin
            m_lvl[i] = m_s[i];
            m_r[i] = m_s[i];
            m_f[i] = !m_s[i];
            m_run[i] = 0;
          end else m_run[i]++;
          md = mode[2*i+:2];
          m_evt[i] = (r_old[i] && (md == EDGE_RISE || md == EDGE_BOTH)) ||
                     (f_old[i] && (md == EDGE_FALL || md == EDGE_BOTH)) || (m_evt[i] && !clr[i]);
        end
        m_irq = |m_evt;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rstn && cmp_on) begin
      chk("serial_o", 32'(sout), 32'(m_lvl));
      chk("r_edge_o", 32'(redge), 32'(m_r));
      chk("f_edge_o", 32'(fedge), 32'(m_f));
      chk("evt_o", 32'(evt), 32'(m_evt));
      chk("irq_o", 32'(irq), 32'(m_irq));
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    en = '1; sin = '0; clr = '0; thr = 8'd3;
    mode = {EDGE_NONE, EDGE_BOTH, EDGE_BOTH, EDGE_RISE};
    #1;
    chk("rst_serial", 32'(sout), 0);
    chk("rst_evt", 32'(evt), 0);
    chk("rst_irq", 32'(irq), 0);
    tick(2); #2 rstn = 1'b1; cmp_on = 1'b1;
    tick(2);
    // 1: T=3 rise on ch0 lands STAGES+T+1 edges after the drive
    sin[0] = 1'b1;
    tick(ST + 3);
    chk("t1_before", 32'(sout[0]), 0);
    tick(1);
    chk("t1_serial", 32'(sout[0]), 1);
    chk("t1_redge", 32'(redge[0]), 1);
    tick(1);
    chk("t1_redge_end", 32'(redge[0]), 0);
    chk("t1_evt", 32'(evt[0]), 1);
    chk("t1_irq", 32'(irq), 1);
    tick(4);
    // 2: 3-cycle glitch rejected, 4-cycle pulse passes
    sin[1] = 1'b1; tick(3); sin[1] = 1'b0; tick(12);
    chk("t2_glitch_serial", 32'(sout[1]), 0);
    chk("t2_glitch_evt", 32'(evt[1]), 0);
    sin[1] = 1'b1; tick(4); sin[1] = 1'b0;
    r_at = -1; f_at = -1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (redge[1]) r_at = k;
      if (fedge[1]) f_at = k;
    end
    chk("t2_rise_seen", 32'(r_at >= 0), 1);
    chk("t2_gap", 32'(f_at - r_at), 4);
    chk("t2_evt", 32'(evt[1]), 1);
    // 3: T=0, every toggle yields a pulse
    thr = 8'd0; pulses = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 16 && k % 2 == 0) sin[2] = ~sin[2];
      tick(1);
      pulses += int'(redge[2]) + int'(fedge[2]);
    end
    chk("t3_pulses", 32'(pulses), 8);
    chk("t3_evt", 32'(evt[2]), 1);
    // 4: clear racing a new matching edge loses; clear alone wins
    thr = 8'd3;
    clr = '1; tick(1); clr = '0;
    chk("t4_clear_all", 32'(evt), 0);
    chk("t4_irq_low", 32'(irq), 0);
    sin[0] = 1'b0; tick(10);
    chk("t4_fall_no_evt", 32'(evt[0]), 0);
    sin[0] = 1'b1;
    for (int k = 0; k < 20 && !redge[0]; k++) tick(1);
    chk("t4_redge", 32'(redge[0]), 1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("t4_set_wins", 32'(evt[0]), 1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("t4_clr_alone", 32'(evt[0]), 0);
    chk("t4_irq_drop", 32'(irq), 0);
    // 5: disabled channel freezes, re-enable needs T+1 cycles
    mode[7:6] = 2'(EDGE_BOTH); en[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin sin[3] = ~sin[3]; tick(2); end
    chk("t5_frozen", 32'(sout[3]), 0);
    chk("t5_no_evt", 32'(evt[3]), 0);
    sin[3] = 1'b1; tick(4); en[3] = 1'b1; tick(3);
    chk("t5_wait", 32'(sout[3]), 0);
    tick(1);
    chk("t5_update", 32'(sout[3]), 1);
    chk("t5_redge", 32'(redge[3]), 1);
    tick(2);
    // 6: async reset mid-count
    thr = 8'd5; sin[0] = 1'b0; tick(4);
    chk("t6_pre_serial", 32'(sout[0]), 1);
    chk("t6_pre_irq", 32'(irq), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_serial", 32'(sout), 0);
    chk("t6_edges", 32'({redge, fedge}), 0);
    chk("t6_evt", 32'(evt), 0);
    chk("t6_irq", 32'(irq), 0);
    sin = '0; tick(3); #2 rstn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      pulses += $countones({redge, fedge});
    end
    chk("t6_no_spurious", 32'(pulses), 0);
    chk("t6_serial_after", 32'(sout), 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thr = 8'($urandom_range(0, 4));
      if (c % 100 == 0) mode = 8'($urandom);
      sin ^= N'($urandom & $urandom & $urandom);
      en = ~N'($urandom & $urandom & $urandom);
      clr = N'($urandom & $urandom & $urandom);
      tick(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
